hazard_fwd_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipeline. Tracks destination registers
//  of instructions in E/M/W, drives the 2-bit choose inputs of the 3-way 32-bit forwarding

---
 rtl/hazard_fwd_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for the 5-stage pipeline.
// Build option: define HAZ_PERF_EN to enable the saturating stall-cycle counter on stall_cnt.
module hazard_fwd_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_rs_used,
  input  logic        d_rt_used,
  input  logic        d_rs_early,
  input  logic        d_rt_early,
  input  logic [4:0]  d_wreg,
  input  logic [1:0]  d_wsrc,
  input  logic        d_md_start,
  input  logic        d_md_div,
  input  logic        d_md_use,
  output logic        stall,
  output logic [1:0]  fwd_d_rs_sel,
  output logic [1:0]  fwd_d_rt_sel,
  output logic [1:0]  fwd_e_rs_sel,
  output logic [1:0]  fwd_e_rt_sel,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_ALU  = 2'b01,
    SRC_LOAD = 2'b10
  } wsrc_t;

  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_M  = 2'b01,
    SEL_W  = 2'b10
  } sel_t;

  logic [4:0] e_wreg, m_wreg, w_wreg, e_rs, e_rt;
  wsrc_t      e_wsrc, m_wsrc, w_wsrc;
  logic [3:0] md_cnt;
  logic       lu_haz, early_e_haz, early_m_haz, md_haz;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] w);
    return (w != '0) && (r == w);
  endfunction

  function automatic sel_t fwd_sel(input logic [4:0] r, input logic [4:0] mw,
                                   input wsrc_t ms, input logic [4:0] ww);
    if (ms == SRC_ALU && hit(r, mw))
      return SEL_M;
    else if (hit(r, ww))
      return SEL_W;
    else
      return SEL_RF;
  endfunction

  always_comb begin
    lu_haz      = (e_wsrc == SRC_LOAD) &&
                  ((d_rs_used && hit(d_rs, e_wreg)) || (d_rt_used && hit(d_rt, e_wreg)));
    early_e_haz = (e_wsrc != SRC_NONE) &&
                  ((d_rs_early && hit(d_rs, e_wreg)) || (d_rt_early && hit(d_rt, e_wreg)));
    early_m_haz = (m_wsrc == SRC_LOAD) &&
                  ((d_rs_early && hit(d_rs, m_wreg)) || (d_rt_early && hit(d_rt, m_wreg)));
    md_haz      = md_busy && d_md_use;
    stall       = lu_haz || early_e_haz || early_m_haz || md_haz;
  end

  always_comb begin
    fwd_d_rs_sel = fwd_sel(d_rs, m_wreg, m_wsrc, w_wreg);
    fwd_d_rt_sel = fwd_sel(d_rt, m_wreg, m_wsrc, w_wreg);
    fwd_e_rs_sel = fwd_sel(e_rs, m_wreg, m_wsrc, w_wreg);
    fwd_e_rt_sel = fwd_sel(e_rt, m_wreg, m_wsrc, w_wreg);
  end

  // A stalled D instruction enters E as a bubble: no destination, no result source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_wreg <= '0;
      e_wsrc <= SRC_NONE;
      e_rs   <= '0;
      e_rt   <= '0;
      m_wreg <= '0;
      m_wsrc <= SRC_NONE;
      w_wreg <= '0;
      w_wsrc <= SRC_NONE;
    end else begin
      e_wreg <= stall ? '0 : d_wreg;
      e_wsrc <= stall ? SRC_NONE : wsrc_t'(d_wsrc);
      e_rs   <= d_rs;
      e_rt   <= d_rt;
      m_wreg <= e_wreg;
      m_wsrc <= e_wsrc;
      w_wreg <= m_wreg;
      w_wsrc <= m_wsrc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      md_cnt <= '0;
    else if (d_md_start && !stall)
      md_cnt <= d_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 4'd1;
  end

  assign md_busy = (md_cnt != '0);

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized plus directed bench for hazard_fwd_ctrl with a queue-based scoreboard
// checked against a stage-list reference model.
module tb_hazard_fwd_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  d_rs = '0, d_rt = '0, d_wreg = '0;
  logic        d_rs_used = 1'b0, d_rt_used = 1'b0, d_rs_early = 1'b0, d_rt_early = 1'b0;
  logic [1:0]  d_wsrc = '0;
  logic        d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic        stall, md_busy;
  logic [1:0]  fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;
  logic [15:0] stall_cnt;

  hazard_fwd_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_rs_early(d_rs_early), .d_rt_early(d_rt_early),
    .d_wreg(d_wreg), .d_wsrc(d_wsrc),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_d_rs_sel(fwd_d_rs_sel), .fwd_d_rt_sel(fwd_d_rt_sel),
    .fwd_e_rs_sel(fwd_e_rs_sel), .fwd_e_rt_sel(fwd_e_rt_sel),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, wreg, wsrc;
  } instr_t;

  typedef struct {
    int stall, drs, drt, ers, ert, busy, scnt;
  } exp_t;

  exp_t   sb[$];
  instr_t pipe[3];   // index 0 = E, 1 = M, 2 = W
  int     md_left;
  int     stalls;
  int     checks = 0;
  int     passed = 0;
  bit     done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic bit hit(input int r, input int w);
    return (w != 0) && (r == w);
  endfunction

  function automatic int sel(input int r);
    if (pipe[1].wsrc == 1 && hit(r, pipe[1].wreg)) return 1;
    if (hit(r, pipe[2].wreg)) return 2;
    return 0;
  endfunction

  function automatic int perf_exp();
`ifdef HAZ_PERF_EN
    return stalls;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    md_left = 0;
    stalls  = 0;
  endtask

  // Apply one D-stage instruction, predict this cycle's outputs, then advance the model.
  task automatic issue(input int rs, input int rt, input bit rsu, input bit rtu,
                       input bit rse, input bit rte, input int wreg, input int wsrc,
                       input bit start, input bit div, input bit use_md);
    exp_t   e;
    instr_t d;
    bit     st;
    @(negedge clk);
    d_rs = 5'(rs); d_rt = 5'(rt); d_rs_used = rsu; d_rt_used = rtu;
    d_rs_early = rse; d_rt_early = rte; d_wreg = 5'(wreg); d_wsrc = 2'(wsrc);
    d_md_start = start; d_md_div = div; d_md_use = use_md;
    st = (pipe[0].wsrc == 2 && ((rsu && hit(rs, pipe[0].wreg)) || (rtu && hit(rt, pipe[0].wreg))))
      || (pipe[0].wsrc != 0 && ((rse && hit(rs, pipe[0].wreg)) || (rte && hit(rt, pipe[0].wreg))))
      || (pipe[1].wsrc == 2 && ((rse && hit(rs, pipe[1].wreg)) || (rte && hit(rt, pipe[1].wreg))))
      || (md_left > 0 && use_md);
    e.stall = int'(st);
    e.drs = sel(rs);
    e.drt = sel(rt);
    e.ers = sel(pipe[0].rs);
    e.ert = sel(pipe[0].rt);
    e.busy = int'(md_left > 0);
    e.scnt = perf_exp();
    sb.push_back(e);
    d = st ? '{rs, rt, 0, 0} : '{rs, rt, wreg, wsrc};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = d;
    if (start && !st) md_left = div ? DIV : MULT;
    else if (md_left > 0) md_left--;
    if (st && stalls < 65535) stalls++;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall", int'(stall), e.stall);
        check("fwd_d_rs_sel", int'(fwd_d_rs_sel), e.drs);
        check("fwd_d_rt_sel", int'(fwd_d_rt_sel), e.drt);
        check("fwd_e_rs_sel", int'(fwd_e_rs_sel), e.ers);
        check("fwd_e_rt_sel", int'(fwd_e_rt_sel), e.ert);
        check("md_busy", int'(md_busy), e.busy);
        check("stall_cnt", int'(stall_cnt), e.scnt);
      end
    end
  end

  initial begin : driver
    model_reset();
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_md_busy", int'(md_busy), 0);
    check("reset_sel", int'({fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel}), 0);
    check("reset_stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $8 then addu $9,$8,$1
    issue(0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0);
    issue(8, 1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    issue(8, 1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    nop(); nop(); nop();
    // addu $8, gap, beq $8,$2 with M forward; then W-only forward
    issue(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    nop();
    issue(8, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    issue(8, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    nop(); nop();
    // addu $8 immediately followed by beq $8
    issue(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    issue(8, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(8, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    nop(); nop(); nop();
    // writes to $0 in flight, D reads $0
    issue(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(0, 0, 1, 1, 1, 1, 3, 1, 0, 0, 0);
    // div then mflo two cycles later, held until HI/LO free
    issue(4, 5, 1, 1, 0, 0, 0, 0, 1, 1, 1);
    nop();
    for (int i = 0; i < 12; i++) issue(0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1);
    nop(); nop(); nop();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      bit rsu, rtu, st;
      r = int'($urandom_range(0, 99));
      st = (r < 6);
      rsu = 1'($urandom_range(0, 1));
      rtu = 1'($urandom_range(0, 1));
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rsu, rtu,
            rsu && ($urandom_range(0, 5) == 0), rtu && ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
            st, 1'($urandom_range(0, 1)), st || (r > 90));
    end

    // async reset while a div is outstanding and mflo waits
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    issue(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_md_busy", int'(md_busy), 0);
    check("rst_mid_stall", int'(stall), 0);
    check("rst_mid_stall_cnt", int'(stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    nop(); nop();
    @(negedge clk);
    #4;
    check("scoreboard_drained", sb.size(), 0);
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #400000;
    join_any
    if (!done) check("timeout", 0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
